dp_ram_param: RTL and testbench

Parametrised simple-dual-port synchronous RAM (one write port, one read port) and the next generation of the fixed 4096-entry RAM.
- Adds configurable width/depth, byte-enable writes and 1- or 2-cycle registered read latency.
- Adds selectable read-during-write behaviour, a collision flag and a hardware clear-on-reset sequencer.
- Sits behind the existing write/read driver interfaces as the storage element under test.

---
 rtl/dp_ram_pkg.sv | 29 ++
 rtl/dp_ram_clear_seq.sv | 51 +++++
 rtl/dp_ram_param.sv | 137 +++++++++++++
 tb/tb_dp_ram_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
// Holds the sequencer state enum, RDW mode codes and the byte-enable merge.
package dp_ram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Widest word the merge helper handles; callers cast to/from this width.
   localparam int MAX_DW = 1024;

   function automatic logic [MAX_DW-1:0] be_merge(
      input logic [MAX_DW-1:0]   i_old,
      input logic [MAX_DW-1:0]   i_new,
      input logic [MAX_DW/8-1:0] i_be
   );
      logic [MAX_DW-1:0] w_res;
      w_res = i_old;
      for (int i = 0; i < MAX_DW/8; i++) begin
         if (i_be[i]) w_res[8*i +: 8] = i_new[8*i +: 8];
      end
      return w_res;
   endfunction

endpackage

// File: rtl/dp_ram_clear_seq.sv
// Clear-on-reset sequencer: walks every address once after reset, then idles.
// Ports: clock, reset (async high) in; clr_we, clr_addr, init_done out.
module dp_ram_clear_seq
   import dp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  init_done
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH:0]   r_cnt;
   logic [ADDR_WIDTH:0]   w_cnt_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The extra counter bit flags that the last address is being written,
   // so READY is entered on the same edge that clears DEPTH-1.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      clr_we      = 1'b0;
      unique case (r_state)
         INIT: begin
            clr_we    = 1'b1;
            w_cnt_nxt = r_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (w_cnt_nxt[ADDR_WIDTH]) w_state_nxt = READY;
         end
         READY: begin
            w_state_nxt = READY;
         end
      endcase
   end

   assign clr_addr  = r_cnt[ADDR_WIDTH-1:0];
   assign init_done = (r_state == READY);

endmodule

// File: rtl/dp_ram_param.sv
// Parametrised simple-dual-port RAM with byte enables, 1/2-cycle read,
// selectable read-during-write, collision flag and clear-on-reset.
// Ports: clock, reset, write/wr_address/data_in/wr_be, read/rd_address in;
//        data_out, rd_valid, collision, init_done out.
module dp_ram_param
   import dp_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 12,
   parameter int                    READ_LATENCY = 1,
   parameter int                    RDW_MODE     = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   wr_address,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    read,
   input  logic [ADDR_WIDTH-1:0]   rd_address,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    rd_valid,
   output logic                    collision,
   output logic                    init_done
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_dw
      $error("dp_ram_param: DATA_WIDTH must be a multiple of 8");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_rl
      $error("dp_ram_param: READ_LATENCY must be 1 or 2");
   end
   if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
      $error("dp_ram_param: RDW_MODE must be 0 or 1");
   end

   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    w_clr_we;
   logic [ADDR_WIDTH-1:0]   w_clr_addr;
   logic                    w_init_done;

   logic                    w_we;
   logic [ADDR_WIDTH-1:0]   w_waddr;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic [DATA_WIDTH/8-1:0] w_wbe;
   logic [DATA_WIDTH-1:0]   w_wword;

   logic                    w_rd_en;
   logic                    w_hit;
   logic [DATA_WIDTH-1:0]   w_rd_word;
   logic [DATA_WIDTH-1:0]   w_byp;
   logic [DATA_WIDTH-1:0]   w_rd_data;

   logic                    r_v1;
   logic                    r_c1;
   logic [DATA_WIDTH-1:0]   r_d1;

   dp_ram_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clr (
      .clock     (clock),
      .reset     (reset),
      .clr_we    (w_clr_we),
      .clr_addr  (w_clr_addr),
      .init_done (w_init_done)
   );

   assign init_done = w_init_done;

   // Sequencer owns the write port until the clear completes.
   assign w_we    = w_init_done ? write      : w_clr_we;
   assign w_waddr = w_init_done ? wr_address : w_clr_addr;
   assign w_wdata = w_init_done ? data_in    : INIT_VALUE;
   assign w_wbe   = w_init_done ? wr_be      : '1;

   assign w_wword = DATA_WIDTH'(be_merge(MAX_DW'(r_mem[w_waddr]),
                                         MAX_DW'(w_wdata),
                                         (MAX_DW/8)'(w_wbe)));

   always_ff @(posedge clock) begin
      if (w_we) r_mem[w_waddr] <= w_wword;
   end

   assign w_rd_en   = read & w_init_done;
   assign w_hit     = w_rd_en & write & (wr_address == rd_address);
   assign w_rd_word = r_mem[rd_address];

   // Write-first bypass: merge the incoming bytes over the stored word.
   assign w_byp = DATA_WIDTH'(be_merge(MAX_DW'(w_rd_word),
                                       MAX_DW'(data_in),
                                       (MAX_DW/8)'(wr_be)));

   assign w_rd_data = (RDW_MODE == RDW_NEW && w_hit) ? w_byp : w_rd_word;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_v1 <= 1'b0;
         r_c1 <= 1'b0;
         r_d1 <= '0;
      end else begin
         r_v1 <= w_rd_en;
         r_c1 <= w_hit;
         if (w_rd_en) r_d1 <= w_rd_data;
      end
   end

   if (READ_LATENCY == 2) begin : g_rl2
      logic                  r_v2;
      logic                  r_c2;
      logic [DATA_WIDTH-1:0] r_d2;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_v2 <= 1'b0;
            r_c2 <= 1'b0;
            r_d2 <= '0;
         end else begin
            r_v2 <= r_v1;
            r_c2 <= r_c1;
            if (r_v1) r_d2 <= r_d1;
         end
      end

      assign data_out  = r_d2;
      assign rd_valid  = r_v2;
      assign collision = r_c2;
   end else begin : g_rl1
      assign data_out  = r_d1;
      assign rd_valid  = r_v1;
      assign collision = r_c1;
   end

endmodule

// File: tb/tb_dp_ram_param.sv
// Scoreboard bench for dp_ram_param: two instances (RL1/old-data, RL2/new-data)
// share stimulus; a queue-based monitor checks every rd_valid pulse.
module tb_dp_ram_param;

   localparam logic [31:0] IV = 32'hC0FFEE00;

   typedef struct {
      logic [31:0] d;
      logic        c;
      int          cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        write = 1'b0;
   logic [3:0]  wr_address = '0;
   logic [31:0] data_in = '0;
   logic [3:0]  wr_be = '0;
   logic        read = 1'b0;
   logic [3:0]  rd_address = '0;

   logic [31:0] dout0, dout1;
   logic        v0, v1, c0, c1, id0, id1;

   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   bit   m_ready = 1'b0;
   logic [31:0] m_mem [16];
   exp_t q0[$];
   exp_t q1[$];

   dp_ram_param #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
      .RDW_MODE(0), .INIT_VALUE(IV)
   ) dut0 (
      .clock(clock), .reset(reset), .write(write),
      .wr_address(wr_address), .data_in(data_in), .wr_be(wr_be),
      .read(read), .rd_address(rd_address), .data_out(dout0),
      .rd_valid(v0), .collision(c0), .init_done(id0)
   );

   dp_ram_param #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
      .RDW_MODE(1), .INIT_VALUE(IV)
   ) dut1 (
      .clock(clock), .reset(reset), .write(write),
      .wr_address(wr_address), .data_in(data_in), .wr_be(wr_be),
      .read(read), .rd_address(rd_address), .data_out(dout1),
      .rd_valid(v1), .collision(c1), .init_done(id1)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] merge(
      input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic mon(input int id, input logic v, input logic c,
                      input logic [31:0] d);
      exp_t e;
      bit   empty;
      if (!v) begin
         chk($sformatf("coll_idle%0d", id), {31'b0, c}, 32'h0);
         return;
      end
      empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
         checks++;
         $display("FAIL unexpected_rd_valid%0d: got data %h expected no pulse",
                  id, d);
         return;
      end
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      chk($sformatf("data%0d", id), d, e.d);
      chk($sformatf("coll%0d", id), {31'b0, c}, {31'b0, e.c});
      chk($sformatf("latency%0d", id), cyc, e.cyc);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         mon(0, v0, c0, dout0);
         mon(1, v1, c1, dout1);
      end
   end

   task automatic io(input bit w, input logic [3:0] wa, input logic [31:0] d,
                     input logic [3:0] be, input bit r, input logic [3:0] ra);
      exp_t e;
      bit   hit;
      write = w; wr_address = wa; data_in = d; wr_be = be;
      read = r;  rd_address = ra;
      if (m_ready && r) begin
         hit   = w && (wa == ra);
         e.c   = hit;
         e.d   = m_mem[ra];
         e.cyc = cyc + 1;
         q0.push_back(e);
         e.d   = hit ? merge(m_mem[ra], d, be) : m_mem[ra];
         e.cyc = cyc + 2;
         q1.push_back(e);
      end
      if (m_ready && w) m_mem[wa] = merge(m_mem[wa], d, be);
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) io(0, 4'h0, 32'h0, 4'h0, 0, 4'h0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      write = 1'b0;
      read  = 1'b0;
      m_ready = 1'b0;
      q0.delete();
      q1.delete();
      #1;
      chk("rst_init_done0", {31'b0, id0}, 32'h0);
      chk("rst_init_done1", {31'b0, id1}, 32'h0);
      chk("rst_rd_valid", {30'b0, v0, v1}, 32'h0);
      chk("rst_collision", {30'b0, c0, c1}, 32'h0);
      chk("rst_data_out0", dout0, 32'h0);
      chk("rst_data_out1", dout1, 32'h0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Reads are issued throughout the clear; none may produce rd_valid.
   task automatic wait_clear();
      int k;
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         io(0, 4'h0, 32'h0, 4'h0, 1, 4'($urandom_range(0, 15)));
         k = i;
         if (id0 && id1) break;
      end
      chk("clear_cycles", k, 16);
      chk("init_done_pair", {30'b0, id0, id1}, 32'h3);
      for (int a = 0; a < 16; a++) m_mem[a] = IV;
      m_ready = 1'b1;
   endtask

   initial begin
      #2;
      apply_reset();
      wait_clear();

      for (int a = 0; a < 16; a++) io(0, 4'h0, 32'h0, 4'h0, 1, 4'(a));
      idle(3);

      io(1, 4'd3, 32'hDEADBEEF, 4'b1111, 0, 4'd0);
      io(1, 4'd3, 32'h11223344, 4'b0101, 0, 4'd0);
      io(0, 4'd0, 32'h0, 4'b0000, 1, 4'd3);
      idle(3);
      chk("merge_model", m_mem[3], 32'hDE22BE44);

      io(1, 4'd5, 32'h00000000, 4'b1111, 0, 4'd0);
      io(1, 4'd5, 32'hA5A5A5A5, 4'b1111, 1, 4'd5);
      io(0, 4'd0, 32'h0, 4'b0000, 1, 4'd5);
      idle(3);

      io(1, 4'd8, 32'h88888888, 4'b1111, 0, 4'd0);
      io(1, 4'd7, 32'h77777777, 4'b1111, 1, 4'd8);
      io(1, 4'd9, 32'h99999999, 4'b0000, 1, 4'd9);
      idle(3);

      for (int i = 0; i < 400; i++) begin
         logic [3:0] wa, ra;
         wa = 4'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
         io($urandom_range(0, 1) == 1, wa, $urandom,
            4'($urandom_range(0, 15)), $urandom_range(0, 4) != 0, ra);
      end
      idle(3);

      reset = 1'b0;
      apply_reset();
      for (int i = 0; i < 5; i++) io(0, 4'h0, 32'h0, 4'h0, 1, 4'(i));
      chk("mid_init_not_done", {30'b0, id0, id1}, 32'h0);
      apply_reset();
      wait_clear();

      io(1, 4'd2, 32'h12345678, 4'b1111, 0, 4'd0);
      io(0, 4'd0, 32'h0, 4'b0000, 1, 4'd2);
      io(0, 4'd0, 32'h0, 4'b0000, 1, 4'd3);
      apply_reset();
      wait_clear();

      for (int a = 0; a < 16; a++) io(0, 4'h0, 32'h0, 4'h0, 1, 4'(a));
      idle(4);

      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
